// File: rtl/mux16_arbiter_pkg.sv
// Shared definitions for the 16-way round-robin datapath arbiter:
// requester count, select width, FSM state type and a one-hot helper.
package mux16_arbiter_pkg;

    localparam int N_REQ = 16;
    localparam int SEL_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Expand a binary owner index into the matching one-hot grant vector.
    function automatic logic [N_REQ-1:0] onehot_of(input logic [SEL_W-1:0] idx);
        logic [N_REQ-1:0] base;
        base = {{(N_REQ-1){1'b0}}, 1'b1};
        return base << idx;
    endfunction

endpackage

// File: rtl/rr_pick16.sv
// Combinational rotate-priority pick: starting at ptr and moving upwards
// (15 wraps to 0), report whether any request is set and the index of the
// first one found.
module rr_pick16
    import mux16_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    // Requests rotated so that bit 0 is the requester at ptr.
    logic [N_REQ-1:0] rot;
    logic [SEL_W-1:0] offset;

    // The 4-bit sum wraps naturally, giving the modulo-16 walk.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rotate
            assign rot[gi] = req[SEL_W'(gi) + ptr];
        end
    endgenerate

    // Lowest set bit of the rotated vector is the closest requester to ptr.
    always_comb begin
        found  = 1'b0;
        offset = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found  = 1'b1;
                offset = SEL_W'(i);
            end
        end
    end

    assign idx = ptr + offset;

endmodule

// File: rtl/mux16_arbiter.sv
// Round-robin owner arbiter for a shared 16:1 datapath. Drives a one-hot
// grant plus the binary select for the mux. Owners release with done or by
// dropping their request; next winner takes over at the same edge.
// Optional feature: define MUX16_ARBITER_TIMEOUT_EN to add a hold counter
// that forcibly rotates ownership after HOLD_MAX cycles when others wait.
module mux16_arbiter
    import mux16_arbiter_pkg::*;
#(
    parameter int HOLD_MAX = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             sel_valid,
    output logic             timeout
);

    // Reject out-of-range hold lengths at elaboration.
    generate
        if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold_max
            $error("mux16_arbiter: HOLD_MAX must be within 1..255");
        end
    endgenerate

    state_t           state_reg;
    logic [N_REQ-1:0] gnt_reg;
    logic [SEL_W-1:0] sel_reg;
    logic [SEL_W-1:0] ptr_reg;
    logic             sel_valid_reg;

    logic             found;
    logic [SEL_W-1:0] pick_idx;
    logic             nat_release;
    logic             force_release;
    logic             release_ev;
    logic             take_grant;

    rr_pick16 u_pick (
        .req   (req),
        .ptr   (ptr_reg),
        .found (found),
        .idx   (pick_idx)
    );

    // The owner lets go either explicitly (done) or by withdrawing its
    // request. Because ptr already sits one past the owner, a still-requesting
    // owner is naturally searched last and only wins if nobody else is waiting.
    assign nat_release = done | ~req[sel_reg];
    assign release_ev  = (state_reg == GRANT) & (nat_release | force_release);
    assign take_grant  = found & ((state_reg == IDLE) | release_ev);

`ifdef MUX16_ARBITER_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    logic [7:0] hold_cnt_reg;
    logic       timeout_reg;
    logic       other_req;

    assign other_req     = |(req & ~gnt_reg);
    // Timeout only fires when the owner would otherwise keep the datapath.
    assign force_release = (state_reg == GRANT) & ~nat_release & other_req &
                           (hold_cnt_reg == HOLD_LAST);

    // Hold counter: restart on each new grant, saturate at the last cycle so
    // a lone owner is kept but loses out as soon as someone else asks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_reg <= '0;
        end else if (take_grant) begin
            hold_cnt_reg <= '0;
        end else if (state_reg == GRANT && hold_cnt_reg != HOLD_LAST) begin
            hold_cnt_reg <= hold_cnt_reg + 8'd1;
        end
    end

    // One-cycle pulse marking the edge where ownership was taken away.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_reg <= 1'b0;
        end else begin
            timeout_reg <= force_release;
        end
    end

    assign timeout = timeout_reg;
`else
    assign force_release = 1'b0;
    assign timeout       = 1'b0;
`endif

    // Ownership FSM: grant/select/pointer are registered together so the
    // one-hot grant always agrees with the select. sel keeps its last value
    // when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            gnt_reg       <= '0;
            sel_reg       <= '0;
            sel_valid_reg <= 1'b0;
            ptr_reg       <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (take_grant) begin
                        state_reg     <= GRANT;
                        gnt_reg       <= onehot_of(pick_idx);
                        sel_reg       <= pick_idx;
                        sel_valid_reg <= 1'b1;
                        ptr_reg       <= pick_idx + 4'd1;
                    end
                end
                GRANT: begin
                    if (take_grant) begin
                        gnt_reg       <= onehot_of(pick_idx);
                        sel_reg       <= pick_idx;
                        sel_valid_reg <= 1'b1;
                        ptr_reg       <= pick_idx + 4'd1;
                    end else if (release_ev) begin
                        state_reg     <= IDLE;
                        gnt_reg       <= '0;
                        sel_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    gnt_reg       <= '0;
                    sel_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign gnt       = gnt_reg;
    assign sel       = sel_reg;
    assign sel_valid = sel_valid_reg;

endmodule

// File: tb/tb_mux16_arbiter.sv
// Self-checking bench for mux16_arbiter: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural owner/pointer model. Honours MUX16_ARBITER_TIMEOUT_EN.
module tb_mux16_arbiter;

    localparam int HOLD = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] req = '0;
    logic        done = 1'b0;
    logic [15:0] gnt;
    logic [3:0]  sel;
    logic        sel_valid;
    logic        timeout;

    int total = 0;
    int bad   = 0;

    mux16_arbiter #(.HOLD_MAX(HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .sel       (sel),
        .sel_valid (sel_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic       m_valid;
    logic [3:0] m_sel;
    int         m_ptr;
    int         m_cnt;
    logic       m_to;

    function automatic int rr_first(input logic [15:0] r, input int start);
        for (int o = 0; o < 16; o++) begin
            if (r[(start + o) % 16]) return (start + o) % 16;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        int   k;
        logic nat;
        logic forced;
`ifdef MUX16_ARBITER_TIMEOUT_EN
        logic others;
`endif
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_sel   <= '0;
            m_ptr   <= 0;
            m_cnt   <= 0;
            m_to    <= 1'b0;
        end else begin
            m_to <= 1'b0;
            if (!m_valid) begin
                k = rr_first(req, m_ptr);
                if (k >= 0) begin
                    m_valid <= 1'b1;
                    m_sel   <= 4'(k);
                    m_ptr   <= (k + 1) % 16;
                    m_cnt   <= 0;
                end
            end else begin
                nat    = done || !req[m_sel];
                forced = 1'b0;
`ifdef MUX16_ARBITER_TIMEOUT_EN
                others = (req & ~(16'h1 << m_sel)) != 16'h0;
                forced = !nat && others && (m_cnt == HOLD - 1);
`endif
                if (nat || forced) begin
                    k = rr_first(req, m_ptr);
                    if (k >= 0) begin
                        m_sel <= 4'(k);
                        m_ptr <= (k + 1) % 16;
                        m_cnt <= 0;
                        m_to  <= forced;
                    end else begin
                        m_valid <= 1'b0;
                    end
                end else if (m_cnt < HOLD - 1) begin
                    m_cnt <= m_cnt + 1;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin : compare
        logic [15:0] exp_gnt;
        exp_gnt = m_valid ? (16'h1 << m_sel) : 16'h0;
        check("cyc_gnt", 32'(gnt), 32'(exp_gnt));
        check("cyc_sel", 32'(sel), 32'(m_sel));
        check("cyc_sel_valid", 32'(sel_valid), 32'(m_valid));
        check("cyc_timeout", 32'(timeout), 32'(m_to));
        check("cyc_invariant", 32'(gnt), sel_valid ? 32'(16'h1 << sel) : 32'h0);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        done  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic expect_owner(input string name, input int owner, input logic to);
        check({name, "_valid"}, 32'(sel_valid), 32'h1);
        check({name, "_sel"}, 32'(sel), 32'(owner));
        check({name, "_gnt"}, 32'(gnt), 32'h1 << owner);
        check({name, "_timeout"}, 32'(timeout), 32'(to));
    endtask

    initial begin
        // Reset state and single-requester grant/drop.
        do_reset();
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_sel", 32'(sel), 32'h0);
        check("rst_valid", 32'(sel_valid), 32'h0);
        check("rst_timeout", 32'(timeout), 32'h0);
        req = 16'h0001;
        tick();
        expect_owner("single", 0, 1'b0);
        $display("txn single grant: sel=%0d gnt=%04h", sel, gnt);
        req = 16'h0000;
        tick();
        check("drop_gnt", 32'(gnt), 32'h0);
        check("drop_valid", 32'(sel_valid), 32'h0);
        check("drop_sel_hold", 32'(sel), 32'h0);
        $display("txn drop: gnt=%04h sel_valid=%0d", gnt, sel_valid);

        // Two requesters alternating via done, no idle bubble.
        do_reset();
        req  = 16'h8001;
        tick();
        expect_owner("alt0", 0, 1'b0);
        done = 1'b1;
        tick();
        expect_owner("alt1", 15, 1'b0);
        tick();
        expect_owner("alt2", 0, 1'b0);
        tick();
        expect_owner("alt3", 15, 1'b0);
        $display("txn alternate: last sel=%0d", sel);

        // Wrap from owner 15 to 0, then 1.
        req = 16'h0003;
        tick();
        expect_owner("wrap0", 0, 1'b0);
        tick();
        expect_owner("wrap1", 1, 1'b0);
        $display("txn wrap: sel=%0d", sel);

        // Asynchronous reset mid-grant.
        done = 1'b0;
        req  = 16'h0002;
        tick();
        expect_owner("pre_rst", 1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_gnt", 32'(gnt), 32'h0);
        check("async_rst_valid", 32'(sel_valid), 32'h0);
        check("async_rst_timeout", 32'(timeout), 32'h0);
        req = 16'h0004;
        tick();
        rst_n = 1'b1;
        tick();
        expect_owner("post_rst", 2, 1'b0);
        $display("txn async reset: sel=%0d", sel);

`ifdef MUX16_ARBITER_TIMEOUT_EN
        // Forced rotation after HOLD cycles with a waiting requester.
        do_reset();
        req = 16'h0030;
        tick();
        expect_owner("hold0", 4, 1'b0);
        for (int i = 1; i < HOLD; i++) begin
            tick();
            expect_owner("hold", 4, 1'b0);
        end
        tick();
        expect_owner("hold_to", 5, 1'b1);
        tick();
        expect_owner("hold_after", 5, 1'b0);
        $display("txn timeout rotate: sel=%0d", sel);
        // Lone requester is never preempted.
        do_reset();
        req = 16'h0010;
        for (int i = 0; i < 20; i++) begin
            tick();
            expect_owner("lone", 4, 1'b0);
        end
        $display("txn lone owner: sel=%0d", sel);
`else
        // Without the timeout feature, a held grant never rotates.
        do_reset();
        req = 16'h0030;
        for (int i = 0; i < 12; i++) begin
            tick();
            expect_owner("nohold", 4, 1'b0);
        end
        $display("txn held owner: sel=%0d", sel);
`endif

        // Randomized traffic checked by the per-cycle compare.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 30) req = 16'($urandom & $urandom);
            done = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 499) == 0) do_reset();
            tick();
        end
        $display("txn random: 3000 cycles issued");

        req  = '0;
        done = 1'b0;
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux16_arbiter.md
MUX16_ARBITER -- requirements
Module: mux16_arbiter

Interface
REQ-001 The block SHALL have parameter HOLD_MAX, default 8, meaning the maximum grant length in cycles when the timeout feature is compiled in (range 1..255).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port req, input, 16 bits: request from requester i on bit i.
REQ-005 The block SHALL have port done, input, 1 bit: pulse from the current owner releasing the shared 16:1 datapath.
REQ-006 The block SHALL have port gnt, output, 16 bits: one-hot grant, all zero when idle.
REQ-007 The block SHALL have port sel, output, 4 bits: binary index of the owner, driven straight to the mux16to1 select.
REQ-008 The block SHALL have port sel_valid, output, 1 bit: high when gnt is non-zero and sel is meaningful.
REQ-009 The block SHALL have port timeout, output, 1 bit: one-cycle pulse on a forced release.

Function
REQ-010 The block SHALL implement two states, IDLE and GRANT; IDLE when gnt==0, GRANT when exactly one gnt bit is set.
REQ-011 IDLE -> GRANT: any req bit high at an edge SHALL register a grant at that edge (1-cycle latency from req to gnt).
REQ-012 Selection SHALL be round-robin: search starts at index ptr and increments modulo 16 (15 wraps to 0); the first set req bit wins.
REQ-013 On every new grant to index k, ptr SHALL be set to (k+1) mod 16.
REQ-014 A release event in GRANT SHALL be: done==1, or req[owner]==0, or a forced timeout (REQ-021).
REQ-015 On a release with other req bits set, the block SHALL stay in GRANT and switch gnt/sel to the next winner at the same edge, with no idle bubble.
REQ-016 On a release with no req bits set, the block SHALL go to IDLE and clear gnt and sel_valid; sel SHALL hold its last value.
REQ-017 If done==1 at release and req[owner] is still 1, the owner SHALL remain eligible, winning only if no other requester is found first from ptr.
REQ-018 done SHALL be ignored in IDLE; req changes of non-owners SHALL NOT affect the current grant.
REQ-019 The invariants gnt == (sel_valid ? 1<<sel : 0) and $onehot0(gnt) SHALL hold every cycle.

Reset
REQ-020 When rst_n is low, the block SHALL immediately, asynchronously force state=IDLE, gnt=0, sel=0, sel_valid=0, timeout=0, ptr=0 and hold count=0; on reset release, normal operation SHALL resume at the next edge, and a grant in progress SHALL be dropped without a timeout pulse.

Configuration
REQ-021 With macro MUX16_ARBITER_TIMEOUT_EN defined, an 8-bit hold counter SHALL clear on each new grant and count GRANT cycles; when it reaches HOLD_MAX-1 and any other req bit is set, the block SHALL force a release, perform the REQ-015 switch and pulse timeout for one cycle.
REQ-022 With the macro defined, a lone requester SHALL never be preempted, and its counter SHALL saturate.
REQ-023 Without the macro, the counter SHALL be absent, timeout SHALL be tied 0, and grants SHALL end only via done or req drop.

Structure
REQ-024 Package mux16_arbiter_pkg SHALL hold N_REQ=16, SEL_W=4 and the state enum {IDLE, GRANT}.
REQ-025 Sub-module rr_pick16 SHALL contain the combinational rotate-priority pick (inputs req and ptr; outputs found and idx).

Verification
REQ-026 Reset then req=0x0001 -> one edge later gnt=0x0001, sel=0, sel_valid=1; drop req -> next edge gnt=0, sel_valid=0.
REQ-027 req=0x8001 with ptr=0, holding req and pulsing done each grant -> owners 0,15,0,15 with no idle cycle between them.
REQ-028 Owner 15 releases with req=0x0003 -> grant goes to 0 (wrap), then 1.
REQ-029 TIMEOUT_EN, HOLD_MAX=4, req=0x0030 held with no done -> owner 4 for 4 cycles, timeout pulse, owner 5; with req=0x0010 alone -> owner 4 is never preempted.
REQ-030 rst_n asserted mid-grant, between edges -> gnt=0 immediately; after release, req=0x0004 -> owner 2 (ptr=0).
